pwc_window_rx: RTL and testbench
================================

# pwc_window_rx

Pulse-width-coded serial receiver with a parametrised sliding-window signed adder. The block decodes words of `W` bits, LSB first, from a single `rxd` line and after every complete word emits the signed sum of the last `DEPTH` received words. Signed overflow is flagged with `ow`; out-of-range pulse lengths are flagged with `err`. It generalises the fixed 8-bit, two-word receiver/adder with configurable width, window depth, pulse thresholds and error reporting, and sits directly behind the line interface of the receive datapath.

## Interface

Parameters:
- `W`, 8: word width in bits; `W` ≥ 2.
- `DEPTH`, 2: number of words in the summing window; `DEPTH` ≥ 1.
- `ONE_MIN`, 2: minimum space length, in cycles, for a 1.
- `ONE_MAX`, 7: maximum space length, in cycles, for a 1.
- `ZERO_MIN`, 11: minimum space length, in cycles, for a 0.
- `ZERO_MAX`, 15: maximum space length, in cycles, for a 0.

Ports:
- `clock` input 1: the only clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `rxd` input 1: line input; mark = 1 (idle), space = 0.
- `out` output W: signed window sum; holds its value between updates.
- `signal` output 1: one-cycle pulse; `out` is valid during the pulse.
- `ow` output 1: one-cycle pulse on signed overflow.
- `err` output 1: one-cycle pulse on a malformed pulse length.

## Operation

- Bit coding:
  - Each bit is a space of length L cycles, followed by a mark of any length ≥ 1.
  - L is the number of consecutive rising edges at which `rxd` is sampled as 0.
  - L in [ONE_MIN, ONE_MAX] decodes as 1; L in [ZERO_MIN, ZERO_MAX] decodes as 0.
  - Any other L is a frame error.
- The length counter saturates at ZERO_MAX+1; a space longer than ZERO_MAX is therefore an error. A space that is still in progress is never an error until its end is seen.
- Bits shift in LSB first. The word is complete on bit index W-1.
- FSM states:
  - IDLE: wait for `rxd`=0, then go to COUNT.
  - COUNT: increment L while `rxd`=0. On `rxd`=1:
    - valid L and bit index < W-1: store the bit and go to IDLE;
    - valid L and bit index = W-1: store the bit and go to SUM;
    - invalid L: go to ERR.
  - ERR: pulse `err`, discard the partial word, reset bit index to 0, leave the window unchanged, go to IDLE.
  - SUM: compute `S = acc + new − oldest`, where `acc` is W+clog2(DEPTH)+1 bits wide with all terms sign-extended; go to EMIT.
  - EMIT:
    - If S lies in [−2^(W−1), 2^(W−1)−1]: `out` ← S[W−1:0], pulse `signal`, push `new` into the window, `acc` ← S.
    - Otherwise, without SATURATE_EN: pulse `ow`, leave `out` unchanged, clear every window entry and `acc` to 0, discard `new`.
    - In both cases go to IDLE.
- The window is a circular buffer of DEPTH entries with a write pointer that wraps modulo DEPTH. The entry overwritten on a push is the "oldest" term. After reset or a clear, all entries are 0, so the first sum equals the first word.
- DEPTH=1: S = new; overflow is impossible.
- The receiver keeps decoding during SUM and EMIT. A space beginning in those cycles is counted normally, because counting is independent of the sum path.

## Timing

- Reset values: `out`=0, `signal`=0, `ow`=0, `err`=0. The FSM is in IDLE with bit index 0, L=0, window and `acc` all 0.
- Reset asserted mid-word or mid-sum aborts everything immediately; no pulse is emitted.
- Latency: the edge that samples the first mark after the last bit's space is edge E. `signal`, `ow` or `err` is high for exactly the cycle after edge E+2; for `err` it is the cycle after edge E+1.
- `signal` and `ow` are never high in the same cycle without SATURATE_EN.
- Between pulses, `out` is stable.

## Configuration

- `PWC_SATURATE_EN` defined: on overflow, `out` ← +2^(W−1)−1 if S > 0, else −2^(W−1). Both `signal` and `ow` pulse in the same cycle. `new` is pushed and `acc` ← S, keeping the exact wide sum so later sums stay exact.
- `PWC_SATURATE_EN` undefined: overflow behaviour is as in Operation (`ow` only, window cleared).

## Structure

- Package `pwc_pkg` holds:
  - the FSM state enum (IDLE, COUNT, ERR, SUM, EMIT);
  - the bit-class enum (ONE, ZERO, BAD);
  - the function `classify(L)`.
- Sub-module `pwc_window`: circular buffer plus accumulator. It has push and clear inputs and provides `oldest` and `acc` outputs.

## Test plan

- Defaults; send 114 then 3 → `signal` with `out`=114, then `signal` with `out`=117.
- Defaults; send 100, 100 → `ow` pulse and no `signal`; then send 5 → `out`=5, confirming the window was cleared.
- DEPTH=4; send 10, 20, 30, 40, 50 → `out` = 10, 30, 60, 100, then `ow` (sum 140); then 7 → `out`=7.
- Defaults; inject a space of 9 cycles at bit 3 → `err` pulse; the next full word 12 → `out` = 12 + previous word.
- Assert `reset` after 5 bits of a word → all outputs 0; the next word 1 → `out`=1.
- With `PWC_SATURATE_EN`, send 100, 100 → `signal`+`ow` with `out`=127; then send −60 → `out`=40.

Source files
------------

// File: rtl/pwc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwc_pkg
//  Description : Shared types and the space-length classifier for the
//                pulse-width-coded window receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwc_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      COUNT = 3'd1,
      ERR   = 3'd2,
      SUM   = 3'd3,
      EMIT  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ONE  = 2'd0,
      ZERO = 2'd1,
      BAD  = 2'd2
   } bit_class_t;

   function automatic bit_class_t classify(
      input int unsigned len,
      input int unsigned one_min,
      input int unsigned one_max,
      input int unsigned zero_min,
      input int unsigned zero_max
   );
      if (len >= one_min && len <= one_max) begin
         return ONE;
      end
      if (len >= zero_min && len <= zero_max) begin
         return ZERO;
      end
      return BAD;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwc_window.sv
`default_nettype none
// ============================================================================
//  Module      : pwc_window
//  Description : DEPTH-entry circular word buffer with a running wide sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwc_window
   import pwc_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int AW    = W + $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic          i_clear,
   input  logic [W-1:0]  i_new,
   input  logic [AW-1:0] i_acc_next,
   output logic [W-1:0]  o_oldest,
   output logic [AW-1:0] o_acc
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [AW-1:0] r_acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr <= '0;
         r_acc  <= '0;
      end else if (i_clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wptr <= '0;
         r_acc  <= '0;
      end else if (i_push) begin
         // The slot being overwritten is the one reported as oldest.
         r_mem[r_wptr] <= i_new;
         r_wptr        <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
         r_acc         <= i_acc_next;
      end
   end

   assign o_oldest = r_mem[r_wptr];
   assign o_acc    = r_acc;

endmodule
`default_nettype wire

// File: rtl/pwc_window_rx.sv
`default_nettype none
// ============================================================================
//  Module      : pwc_window_rx
//  Description : Pulse-width-coded serial receiver with sliding-window signed
//                sum. Optional macro PWC_SATURATE_EN saturates instead of
//                clearing the window on overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwc_window_rx
   import pwc_pkg::*;
#(
   parameter int W        = 8,
   parameter int DEPTH    = 2,
   parameter int ONE_MIN  = 2,
   parameter int ONE_MAX  = 7,
   parameter int ZERO_MIN = 11,
   parameter int ZERO_MAX = 15
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         rxd,
   output logic [W-1:0] out,
   output logic         signal,
   output logic         ow,
   output logic         err
);

   localparam int AW = W + $clog2(DEPTH) + 1;
   localparam int LW = $clog2(ZERO_MAX + 2);
   localparam int BW = $clog2(W);
   localparam logic signed [AW-1:0] c_max = AW'((2 ** (W - 1)) - 1);
   localparam logic signed [AW-1:0] c_min = AW'(-(2 ** (W - 1)));

   state_t                r_rx_state;
   state_t                r_sum_state;
   logic [LW-1:0]         r_len;
   logic [BW-1:0]         r_bit_idx;
   logic [W-2:0]          r_shift;
   logic [W-1:0]          r_new;
   logic signed [AW-1:0]  r_sum;

   bit_class_t            w_class;
   logic [W-1:0]          w_word;
   logic                  w_in_range;
   logic                  w_push;
   logic                  w_clear;
   logic [W-1:0]          w_oldest;
   logic [AW-1:0]         w_acc;

   assign w_class    = classify(32'(r_len), ONE_MIN, ONE_MAX, ZERO_MIN, ZERO_MAX);
   assign w_word     = {(w_class == ONE), r_shift};
   assign w_in_range = (r_sum >= c_min) && (r_sum <= c_max);

   always_comb begin
      w_push  = 1'b0;
      w_clear = 1'b0;
`ifdef PWC_SATURATE_EN
      w_push  = (r_sum_state == EMIT);
`else
      w_push  = (r_sum_state == EMIT) && w_in_range;
      w_clear = (r_sum_state == EMIT) && !w_in_range;
`endif
   end

   pwc_window #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_window (
      .clk        (clock),
      .rst        (reset),
      .i_push     (w_push),
      .i_clear    (w_clear),
      .i_new      (r_new),
      .i_acc_next (r_sum),
      .o_oldest   (w_oldest),
      .o_acc      (w_acc)
   );

   // Decoder and sum path advance independently so a new space can start
   // while the previous word is still being summed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rx_state  <= IDLE;
         r_sum_state <= IDLE;
         r_len       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_new       <= '0;
         r_sum       <= '0;
         out         <= '0;
         signal      <= 1'b0;
         ow          <= 1'b0;
         err         <= 1'b0;
      end else begin
         err    <= (r_rx_state == ERR);
         signal <= 1'b0;
         ow     <= 1'b0;

         case (r_rx_state)
            COUNT: begin
               if (!rxd) begin
                  if (r_len != LW'(ZERO_MAX + 1)) begin
                     r_len <= r_len + LW'(1);
                  end
               end else begin
                  r_len      <= '0;
                  r_rx_state <= IDLE;
                  if (w_class == BAD) begin
                     r_rx_state <= ERR;
                     r_bit_idx  <= '0;
                  end else begin
                     r_shift <= w_word[W-1:1];
                     if (r_bit_idx == BW'(W - 1)) begin
                        r_bit_idx   <= '0;
                        r_new       <= w_word;
                        r_sum_state <= SUM;
                     end else begin
                        r_bit_idx <= r_bit_idx + BW'(1);
                     end
                  end
               end
            end
            default: begin
               if (!rxd) begin
                  r_rx_state <= COUNT;
                  r_len      <= LW'(1);
               end else begin
                  r_rx_state <= IDLE;
               end
            end
         endcase

         case (r_sum_state)
            SUM: begin
               r_sum <= w_acc
                      + {{(AW - W){r_new[W-1]}}, r_new}
                      - {{(AW - W){w_oldest[W-1]}}, w_oldest};
               r_sum_state <= EMIT;
            end
            EMIT: begin
               r_sum_state <= IDLE;
`ifdef PWC_SATURATE_EN
               signal <= 1'b1;
               if (w_in_range) begin
                  out <= r_sum[W-1:0];
               end else begin
                  ow  <= 1'b1;
                  out <= r_sum[AW-1] ? c_min[W-1:0] : c_max[W-1:0];
               end
`else
               if (w_in_range) begin
                  out    <= r_sum[W-1:0];
                  signal <= 1'b1;
               end else begin
                  ow <= 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pwc_window_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwc_window_rx
//  Description : Scoreboard bench for pwc_window_rx (DEPTH=2 and DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwc_window_rx;

   localparam logic [2:0] K_SIG = 3'b100;
   localparam logic [2:0] K_OW  = 3'b010;
   localparam logic [2:0] K_ERR = 3'b001;
   localparam logic [2:0] K_SAT = 3'b110;

   typedef struct {
      logic [2:0] kind;
      logic [7:0] val;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd_a, rxd_b;
   logic [7:0] out_a, out_b;
   logic       sig_a, ow_a, err_a;
   logic       sig_b, ow_b, err_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   pwc_window_rx #(.W(8), .DEPTH(2)) u_dut_a (
      .clock (clk), .reset (rst), .rxd (rxd_a),
      .out (out_a), .signal (sig_a), .ow (ow_a), .err (err_a)
   );

   pwc_window_rx #(.W(8), .DEPTH(4)) u_dut_b (
      .clock (clk), .reset (rst), .rxd (rxd_b),
      .out (out_b), .signal (sig_b), .ow (ow_b), .err (err_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin : mon_a
      exp_t       e;
      logic [7:0] prev;
      if (rst) begin
         prev = 8'h00;
      end else begin
         if (sig_a | ow_a | err_a) begin
            if (q_a.size() == 0) begin
               check("A_unexpected", {sig_a, ow_a, err_a}, 3'b000);
            end else begin
               e = q_a.pop_front();
               check("A_kind", {sig_a, ow_a, err_a}, e.kind);
               if (e.kind[2]) check("A_out", out_a, e.val);
            end
         end
         if (!sig_a) check("A_hold", out_a, prev);
         prev = out_a;
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t       e;
      logic [7:0] prev;
      if (rst) begin
         prev = 8'h00;
      end else begin
         if (sig_b | ow_b | err_b) begin
            if (q_b.size() == 0) begin
               check("B_unexpected", {sig_b, ow_b, err_b}, 3'b000);
            end else begin
               e = q_b.pop_front();
               check("B_kind", {sig_b, ow_b, err_b}, e.kind);
               if (e.kind[2]) check("B_out", out_b, e.val);
            end
         end
         if (!sig_b) check("B_hold", out_b, prev);
         prev = out_b;
      end
   end

   task automatic drive(input int which, input logic v);
      if (which == 0) rxd_a = v;
      else            rxd_b = v;
   endtask

   task automatic push_exp(input int which, input logic [2:0] kind, input logic [7:0] val);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      if (which == 0) q_a.push_back(e);
      else            q_b.push_back(e);
   endtask

   task automatic send_bit(input int which, input int len, input int mark);
      @(negedge clk);
      drive(which, 1'b0);
      repeat (len) @(posedge clk);
      @(negedge clk);
      drive(which, 1'b1);
      repeat (mark) @(posedge clk);
   endtask

   task automatic send_bits(input int which, input logic [7:0] val, input int nbits,
                            input int mark, input bit edge_len);
      int len;
      for (int i = 0; i < nbits; i++) begin
         if (val[i]) len = edge_len ? ((i % 2) ? 7 : 2) : 4;
         else        len = edge_len ? ((i % 2) ? 15 : 11) : 13;
         send_bit(which, len, mark);
      end
   endtask

   task automatic send_word(input int which, input logic [7:0] val, input logic [2:0] kind,
                            input logic [7:0] expv, input int mark = 2, input bit edge_len = 1'b0);
      push_exp(which, kind, expv);
      send_bits(which, val, 8, mark, edge_len);
   endtask

   task automatic drain();
      int n = 0;
      while ((q_a.size() + q_b.size()) != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      check("drain", q_a.size() + q_b.size(), 0);
      repeat (4) @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      rxd_a = 1'b1;
      rxd_b = 1'b1;
      @(negedge clk);
      check("rst_out_a",    out_a, 8'h00);
      check("rst_pulses_a", {sig_a, ow_a, err_a}, 3'b000);
      check("rst_out_b",    out_b, 8'h00);
      check("rst_pulses_b", {sig_b, ow_b, err_b}, 3'b000);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      rxd_a = 1'b1;
      rxd_b = 1'b1;
      repeat (2) @(posedge clk);
      do_reset();

      // Basic two-word window
      send_word(0, 8'd114, K_SIG, 8'd114);
      send_word(0, 8'd3,   K_SIG, 8'd117);
      drain();

      // Overflow
      do_reset();
      send_word(0, 8'd100, K_SIG, 8'd100);
`ifdef PWC_SATURATE_EN
      send_word(0, 8'd100, K_SAT, 8'd127);
      send_word(0, 8'hC4,  K_SIG, 8'd40);
`else
      send_word(0, 8'd100, K_OW,  8'd0);
      send_word(0, 8'd5,   K_SIG, 8'd5);
`endif
      drain();

      // Range edges, boundary space lengths, single-cycle marks
      do_reset();
      send_word(0, 8'd100, K_SIG, 8'd100, 1, 1'b1);
      send_word(0, 8'd27,  K_SIG, 8'd127, 1, 1'b1);
      send_word(0, 8'd28,  K_SIG, 8'd55,  1, 1'b1);
      drain();
      do_reset();
      send_word(0, 8'h9C, K_SIG, 8'h9C);
      send_word(0, 8'hE4, K_SIG, 8'h80);
      send_word(0, 8'hFF, K_SIG, 8'hE3);
      drain();

      // Frame errors
      do_reset();
      send_word(0, 8'd50, K_SIG, 8'd50);
      push_exp(0, K_ERR, 8'd0);
      send_bits(0, 8'd12, 3, 2, 1'b0);
      send_bit(0, 9, 2);
      send_word(0, 8'd12, K_SIG, 8'd62);
      push_exp(0, K_ERR, 8'd0);
      send_bit(0, 1, 2);
      push_exp(0, K_ERR, 8'd0);
      send_bit(0, 16, 2);
      push_exp(0, K_ERR, 8'd0);
      send_bit(0, 20, 2);
      send_word(0, 8'd1, K_SIG, 8'd13);
      drain();

      // Reset in the middle of a word
      send_bits(0, 8'hFF, 5, 2, 1'b0);
      do_reset();
      send_word(0, 8'd1, K_SIG, 8'd1);
      drain();

      // Four-deep window
      do_reset();
      send_word(1, 8'd10, K_SIG, 8'd10);
      send_word(1, 8'd20, K_SIG, 8'd30);
      send_word(1, 8'd30, K_SIG, 8'd60);
      send_word(1, 8'd40, K_SIG, 8'd100);
`ifdef PWC_SATURATE_EN
      send_word(1, 8'd50, K_SAT, 8'd127);
      send_word(1, 8'd7,  K_SIG, 8'd127);
`else
      send_word(1, 8'd50, K_OW,  8'd0);
      send_word(1, 8'd7,  K_SIG, 8'd7);
`endif
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
